draw_text_overlay: RTL and testbench



---
 rtl/vga_if.sv | 13 +
 rtl/draw_text_overlay.sv | 167 ++++++++++++++++
 tb/tb_draw_text_overlay.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_if.sv
// VGA pixel stream bundle: timing counters, syncs, blanks and 12-bit colour.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_text_overlay.sv
// Text-window overlay: maps each pixel to a character cell and glyph line, drives the font ROM
// address, delays all timing by ROM_LAT + 2 cycles and paints glyph pixels over the video.
module draw_text_overlay #(
    parameter int unsigned X0           = 0,
    parameter int unsigned Y0           = 0,
    parameter int unsigned COLUMNS      = 16,
    parameter int unsigned ROWS         = 16,
    parameter int unsigned CWIDTH       = 8,
    parameter int unsigned CHEIGHT      = 16,
    parameter int unsigned SCALE_LOG2   = 0,
    parameter int unsigned ROM_LAT      = 1,
    parameter logic [11:0] FG_COLOR     = 12'hfff,
    parameter logic [11:0] BG_COLOR     = 12'h000,
    parameter bit          TRANSPARENT  = 1'b0,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    enable,
    input  logic                                    blink_en,
    input  logic [CWIDTH-1:0]                       char_pixel,
    output logic [$clog2(COLUMNS)+$clog2(ROWS)-1:0] char_xy,
    output logic [$clog2(CHEIGHT)-1:0]              char_line,
    vga_if.in                                       in,
    vga_if.out                                      out
);

    localparam int unsigned ColW  = $clog2(COLUMNS);
    localparam int unsigned RowW  = $clog2(ROWS);
    localparam int unsigned LineW = $clog2(CHEIGHT);
    localparam int unsigned CwLog = $clog2(CWIDTH);
    localparam int unsigned BitW  = (CWIDTH > 1) ? CwLog : 1;
    localparam int unsigned WinW  = COLUMNS * CWIDTH * (1 << SCALE_LOG2);
    localparam int unsigned WinH  = ROWS * CHEIGHT * (1 << SCALE_LOG2);
    localparam int unsigned CntW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [10:0]     X0W     = 11'(X0);
    localparam logic [10:0]     Y0W     = 11'(Y0);
    localparam logic [11:0]     XEnd    = 12'(X0 + WinW);
    localparam logic [11:0]     YEnd    = 12'(Y0 + WinH);
    localparam logic [10:0]     CwMask  = 11'(CWIDTH - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(BLINK_FRAMES - 1);

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } vga_t;

    // Per-pixel payload carried alongside the ROM access.
    typedef struct packed {
        vga_t            v;
        logic            act;    // inside window and overlay enabled
        logic            blank;  // glyph suppressed by blink phase
        logic [BitW-1:0] bi;     // glyph bit to pick from char_pixel
    } pix_t;

    pix_t pipe_d [ROM_LAT+1];
    pix_t pipe_q [ROM_LAT+1];
    vga_t out_d, out_q;

    logic [ColW+RowW-1:0] xy_d, xy_q;
    logic [LineW-1:0]     line_d, line_q;
    logic [CntW-1:0]      cnt_d, cnt_q;
    logic                 phase_d, phase_q;
    logic                 vsync_prev_q;

    logic [10:0] dx, dy, fx, fy;
    logic        active;
    logic        glyph;

    // Stage 0: window test, cell address and bit index; then the ROM-latency delay line.
    always_comb begin
        dx     = in.hcount - X0W;
        dy     = in.vcount - Y0W;
        fx     = dx >> SCALE_LOG2;
        fy     = dy >> SCALE_LOG2;
        active = (in.hcount >= X0W) && ({1'b0, in.hcount} < XEnd) &&
                 (in.vcount >= Y0W) && ({1'b0, in.vcount} < YEnd);
        xy_d   = xy_q;
        line_d = line_q;
        if (active) begin
            xy_d   = {ColW'(fx >> CwLog), RowW'(fy >> LineW)};
            line_d = LineW'(fy);
        end
        pipe_d[0].v.hcount = in.hcount;
        pipe_d[0].v.vcount = in.vcount;
        pipe_d[0].v.hsync  = in.hsync;
        pipe_d[0].v.vsync  = in.vsync;
        pipe_d[0].v.hblnk  = in.hblnk;
        pipe_d[0].v.vblnk  = in.vblnk;
        pipe_d[0].v.rgb    = in.rgb;
        pipe_d[0].act      = active & enable;
        pipe_d[0].blank    = blink_en & phase_q;
        pipe_d[0].bi       = BitW'(CwMask - (fx & CwMask));
        for (int k = 1; k <= ROM_LAT; k++) begin
            pipe_d[k] = pipe_q[k-1];
        end
    end

    // Frame counter on registered vsync rising edge; blink phase toggles at wrap.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (in.vsync && !vsync_prev_q) begin
            if (cnt_q == CntLast) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Output stage: char_pixel is aligned with the last delay-line entry.
    always_comb begin
        out_d = pipe_q[ROM_LAT].v;
        glyph = char_pixel[pipe_q[ROM_LAT].bi] & ~pipe_q[ROM_LAT].blank;
        if (pipe_q[ROM_LAT].act) begin
            if (glyph) begin
                out_d.rgb = FG_COLOR;
            end else if (!TRANSPARENT) begin
                out_d.rgb = BG_COLOR;
            end
        end
    end

    // State registers; reset discards every in-flight pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= ROM_LAT; k++) begin
                pipe_q[k] <= '0;
            end
            out_q        <= '0;
            xy_q         <= '0;
            line_q       <= '0;
            cnt_q        <= '0;
            phase_q      <= 1'b0;
            vsync_prev_q <= 1'b0;
        end else begin
            for (int k = 0; k <= ROM_LAT; k++) begin
                pipe_q[k] <= pipe_d[k];
            end
            out_q        <= out_d;
            xy_q         <= xy_d;
            line_q       <= line_d;
            cnt_q        <= cnt_d;
            phase_q      <= phase_d;
            vsync_prev_q <= in.vsync;
        end
    end

    assign char_xy    = xy_q;
    assign char_line  = line_q;
    assign out.hcount = out_q.hcount;
    assign out.vcount = out_q.vcount;
    assign out.hsync  = out_q.hsync;
    assign out.vsync  = out_q.vsync;
    assign out.hblnk  = out_q.hblnk;
    assign out.vblnk  = out_q.vblnk;
    assign out.rgb    = out_q.rgb;

endmodule

// File: tb/tb_draw_text_overlay.sv
// Scoreboard bench: dut_a uses defaults with BLINK_FRAMES=2 (latency 3), dut_b uses
// SCALE_LOG2=1, ROM_LAT=3, TRANSPARENT=1 (latency 5). Both share the input stream.
module tb_draw_text_overlay;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       blink_en;
    logic [7:0] cp_a, cp_b;
    logic [7:0] xy_a, xy_b;
    logic [3:0] line_a, line_b;

    vga_if vin ();
    vga_if vout_a ();
    vga_if vout_b ();

    always #5 clk = ~clk;

    draw_text_overlay #(.BLINK_FRAMES(2)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .blink_en   (blink_en),
        .char_pixel (cp_a),
        .char_xy    (xy_a),
        .char_line  (line_a),
        .in         (vin),
        .out        (vout_a)
    );

    draw_text_overlay #(.SCALE_LOG2(1), .ROM_LAT(3), .TRANSPARENT(1'b1)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .blink_en   (blink_en),
        .char_pixel (cp_b),
        .char_xy    (xy_b),
        .char_line  (line_b),
        .in         (vin),
        .out        (vout_b)
    );

    typedef struct {
        int          dut;
        int          due;
        bit          is_char;
        logic [10:0] h;
        logic [10:0] v;
        logic [3:0]  tim;   // {hsync, vsync, hblnk, vblnk}
        logic [11:0] rgb;
        logic [7:0]  xy;
        logic [3:0]  line;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] rom_a[int];
    logic [7:0] rom_b[int];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Font ROM stand-in: presents each pixel's glyph row in the cycle the DUT consumes it.
    always @(posedge clk) begin
        #1;
        cp_a = rom_a.exists(cyc) ? rom_a[cyc] : 8'h00;
        cp_b = rom_b.exists(cyc) ? rom_b[cyc] : 8'h00;
    end

    task automatic check(input exp_t e);
        logic [37:0] got, want;
        if (e.is_char) begin
            got  = {26'd0, (e.dut == 0) ? xy_a : xy_b, (e.dut == 0) ? line_a : line_b};
            want = {26'd0, e.xy, e.line};
        end else begin
            if (e.dut == 0)
                got = {vout_a.hcount, vout_a.vcount, vout_a.hsync, vout_a.vsync,
                       vout_a.hblnk, vout_a.vblnk, vout_a.rgb};
            else
                got = {vout_b.hcount, vout_b.vcount, vout_b.hsync, vout_b.vsync,
                       vout_b.hblnk, vout_b.vblnk, vout_b.rgb};
            want = {e.h, e.v, e.tim, e.rgb};
        end
        checks++;
        if (e.due != cyc || got !== want) begin
            errors++;
            $display("FAIL %s dut%0d due=%0d at=%0d: got %h expected %h",
                     e.is_char ? "char_addr" : "pixel_out", e.dut, e.due, cyc, got, want);
        end
    endtask

    // Monitor: compare every expectation that has come due at this sampling point.
    always @(negedge clk) begin
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].due <= cyc) begin
                check(sb[i]);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic push_zero();
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            e = '{dut: d, due: cyc, is_char: 1'b0, h: '0, v: '0, tim: '0, rgb: '0,
                  xy: '0, line: '0};
            sb.push_back(e);
            e.is_char = 1'b1;
            sb.push_back(e);
        end
    endtask

    // One pixel per call; cp is the glyph row the ROM returns for this pixel.
    task automatic vec(input int sel, input int h, input int v, input logic [11:0] rgb,
                       input logic en, input logic ben, input logic [3:0] tim,
                       input logic [7:0] cp, input logic [11:0] exp_rgb,
                       input bit chk_char, input logic [7:0] exy, input logic [3:0] eln);
        exp_t e;
        @(posedge clk);
        #1;
        vin.hcount = 11'(h);
        vin.vcount = 11'(v);
        vin.rgb    = rgb;
        {vin.hsync, vin.vsync, vin.hblnk, vin.vblnk} = tim;
        enable   = en;
        blink_en = ben;
        if (sel == 0) rom_a[cyc + 2] = cp;
        else          rom_b[cyc + 4] = cp;
        e = '{dut: sel, due: cyc + ((sel == 0) ? 3 : 5), is_char: 1'b0, h: 11'(h),
              v: 11'(v), tim: tim, rgb: exp_rgb, xy: '0, line: '0};
        sb.push_back(e);
        if (chk_char) begin
            e.due     = cyc + 1;
            e.is_char = 1'b1;
            e.xy      = exy;
            e.line    = eln;
            sb.push_back(e);
        end
    endtask

    task automatic pix(input logic ben, input logic [11:0] exp_rgb);
        vec(0, 0, 0, 12'h111, 1'b1, ben, 4'b0000, 8'hff, exp_rgb, 1'b0, 8'h00, 4'd0);
    endtask

    task automatic vs();
        vec(0, 200, 300, 12'h222, 1'b1, 1'b1, 4'b0100, 8'h00, 12'h222, 1'b0, 8'h00, 4'd0);
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic mid_reset();
        int i;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].due >= cyc) sb.delete(i);
            else i++;
        end
        push_zero();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b0;
        blink_en   = 1'b0;
        vin.hcount = '0;
        vin.vcount = '0;
        vin.rgb    = '0;
        {vin.hsync, vin.vsync, vin.hblnk, vin.vblnk} = 4'b0000;

        // Reset held with toggling inputs: everything stays zero.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            vin.hcount = 11'(i * 37 + 3);
            vin.vcount = 11'(i * 11 + 1);
            vin.rgb    = 12'(i * 291 + 5);
            {vin.hsync, vin.vsync, vin.hblnk, vin.vblnk} = 4'(i * 5 + 3);
            enable   = 1'b1;
            blink_en = 1'b1;
            push_zero();
        end
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        vin.vsync = 1'b0;

        // dut_a: default geometry, opaque, latency 3.
        vec(0,   5,   7, 12'h123, 1'b0, 1'b0, 4'b0000, 8'h00, 12'h123, 1'b1, 8'h00, 4'd7);
        vec(0,   9,  18, 12'h456, 1'b1, 1'b0, 4'b0000, 8'h40, 12'hfff, 1'b1, 8'h11, 4'd2);
        vec(0,   8,  18, 12'h456, 1'b1, 1'b0, 4'b0000, 8'h40, 12'h000, 1'b1, 8'h11, 4'd2);
        vec(0, 127, 255, 12'h5a5, 1'b1, 1'b0, 4'b0000, 8'h01, 12'hfff, 1'b1, 8'hff, 4'd15);
        vec(0, 128,   0, 12'h789, 1'b1, 1'b0, 4'b1010, 8'hff, 12'h789, 1'b1, 8'hff, 4'd15);
        vec(0,   0, 256, 12'habc, 1'b1, 1'b0, 4'b0001, 8'hff, 12'habc, 1'b1, 8'hff, 4'd15);
        vec(0,  16,   0, 12'h5a5, 1'b1, 1'b0, 4'b0000, 8'h80, 12'hfff, 1'b1, 8'h20, 4'd0);
        vec(0,  17,   0, 12'h5a5, 1'b1, 1'b0, 4'b0000, 8'h80, 12'h000, 1'b1, 8'h20, 4'd0);
        vec(0,  40,   3, 12'h321, 1'b0, 1'b0, 4'b0000, 8'hff, 12'h321, 1'b1, 8'h50, 4'd3);

        // dut_b: 2x scaling, transparent background, latency 5.
        vec(1,   0,   0, 12'h0a0, 1'b1, 1'b0, 4'b0000, 8'h80, 12'hfff, 1'b1, 8'h00, 4'd0);
        vec(1,   1,   0, 12'h0a0, 1'b1, 1'b0, 4'b0000, 8'h80, 12'hfff, 1'b1, 8'h00, 4'd0);
        vec(1,   2,   0, 12'h0a0, 1'b1, 1'b0, 4'b0000, 8'h80, 12'h0a0, 1'b1, 8'h00, 4'd0);
        vec(1,   3,   0, 12'h0a0, 1'b1, 1'b0, 4'b0000, 8'h40, 12'hfff, 1'b1, 8'h00, 4'd0);
        vec(1, 256,   0, 12'h0a0, 1'b1, 1'b0, 4'b1000, 8'hff, 12'h0a0, 1'b1, 8'h00, 4'd0);
        vec(1, 255, 511, 12'h0a0, 1'b1, 1'b0, 4'b0000, 8'h01, 12'hfff, 1'b1, 8'hff, 4'd15);
        vec(1,  18,  36, 12'h0a0, 1'b1, 1'b0, 4'b0000, 8'h40, 12'hfff, 1'b1, 8'h11, 4'd2);
        vec(1,   4,   2, 12'h0a0, 1'b0, 1'b0, 4'b0000, 8'hff, 12'h0a0, 1'b1, 8'h00, 4'd1);
        vec(1,   6,   0, 12'h0a0, 1'b1, 1'b0, 4'b0000, 8'h00, 12'h0a0, 1'b1, 8'h00, 4'd0);

        // Blink on dut_a with BLINK_FRAMES=2: phase flips every second vsync.
        pix(1'b1, 12'hfff);
        vs();
        pix(1'b1, 12'hfff);
        vs();
        pix(1'b1, 12'h000);
        pix(1'b0, 12'hfff);
        vs();
        pix(1'b1, 12'h000);
        vs();
        pix(1'b1, 12'hfff);
        vs();
        pix(1'b1, 12'hfff);
        vs();
        pix(1'b1, 12'h000);
        vs();
        pix(1'b1, 12'h000);
        settle(4);

        // Mid-stream reset with phase=1 and counter=1: both must restart from zero.
        mid_reset();
        pix(1'b1, 12'hfff);
        vs();
        pix(1'b1, 12'hfff);
        vs();
        pix(1'b1, 12'h000);

        settle(8);
        while (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL pending dut%0d due=%0d: got no sample expected a compare",
                     sb[0].dut, sb[0].due);
            sb.delete(0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
